ball_motion_ctrl: RTL and testbench

//   Parametrised successor to the 8-bit pong ball logic. Moves one ball in a

---
 rtl/ball_motion_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_ball_motion_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_ctrl.sv
// Ball position controller: moves one ball through a bounded 2-D field, one step per tick,
// with a serve handshake and a selectable horizontal edge mode (bounce / wrap / goal).
module ball_motion_ctrl #(
    parameter int H_MAX      = 20,
    parameter int V_MAX      = 20,
    parameter int POS_W      = 9,
    parameter int SPD_W      = 4,
    parameter int START_H    = 10,
    parameter int START_V    = 10,
    parameter int H_MODE     = 0,
    parameter int HOLD_TICKS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             serve_valid,
    output logic             serve_ready,
    input  logic [SPD_W-1:0] serve_hspeed,
    input  logic [SPD_W-1:0] serve_vspeed,
    input  logic             serve_hdir,
    input  logic             serve_vdir,
    output logic [POS_W-1:0] ball_hpos,
    output logic [POS_W-1:0] ball_vpos,
    output logic             ball_hdir,
    output logic             ball_vdir,
    output logic             active,
    output logic             h_bounce,
    output logic             v_bounce,
    output logic             goal_left,
    output logic             goal_right
);

    typedef enum logic [1:0] {IDLE, MOVING, HOLD} state_t;

    // Two guard bits: one for sign, one so 2*MAX never overflows.
    localparam int EW = POS_W + 2;
    typedef logic signed [EW-1:0] ext_t;

    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic             dir;
        logic             pulse;
    } axis_t;

    localparam ext_t H_LIM = ext_t'(H_MAX);
    localparam ext_t V_LIM = ext_t'(V_MAX);
    localparam logic [POS_W-1:0] START_H_P = POS_W'(START_H);
    localparam logic [POS_W-1:0] START_V_P = POS_W'(START_V);
    localparam logic [POS_W-1:0] H_MAX_P   = POS_W'(H_MAX);
    localparam int CNT_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TICKS - 1);

    state_t           state_q, state_d;
    logic [POS_W-1:0] hpos_q, hpos_d, vpos_q, vpos_d;
    logic             hdir_q, hdir_d, vdir_q, vdir_d;
    logic [SPD_W-1:0] hspd_q, hspd_d, vspd_q, vspd_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             h_bounce_d, v_bounce_d, goal_left_d, goal_right_d;

    axis_t v_step, h_step;
    ext_t  h_n;

    function automatic ext_t next_pos(input logic [POS_W-1:0] pos,
                                      input logic [SPD_W-1:0] spd,
                                      input logic             dir);
        ext_t p, s;
        p = ext_t'({2'b00, pos});
        s = ext_t'({{(EW-SPD_W){1'b0}}, spd});
        return dir ? (p - s) : (p + s);
    endfunction

    function automatic axis_t bounce_step(input logic [POS_W-1:0] pos,
                                          input logic [SPD_W-1:0] spd,
                                          input logic             dir,
                                          input ext_t             lim);
        axis_t r;
        ext_t  n;
        r.pos   = pos;
        r.dir   = dir;
        r.pulse = 1'b0;
        n = next_pos(pos, spd, dir);
        if (spd != '0) begin
            if (n > lim) begin
                r.pos   = POS_W'(lim + lim - n);
                r.dir   = ~dir;
                r.pulse = 1'b1;
            end else if (n[EW-1]) begin
                r.pos   = POS_W'(-n);
                r.dir   = ~dir;
                r.pulse = 1'b1;
            end else if ((n == lim && !dir) || (n == '0 && dir)) begin
                // Landing exactly on the edge while heading into it still reflects.
                r.pos   = POS_W'(n);
                r.dir   = ~dir;
                r.pulse = 1'b1;
            end else begin
                r.pos = POS_W'(n);
            end
        end
        return r;
    endfunction

    assign v_step = bounce_step(vpos_q, vspd_q, vdir_q, V_LIM);
    assign h_step = bounce_step(hpos_q, hspd_q, hdir_q, H_LIM);
    assign h_n    = next_pos(hpos_q, hspd_q, hdir_q);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        hpos_d       = hpos_q;
        vpos_d       = vpos_q;
        hdir_d       = hdir_q;
        vdir_d       = vdir_q;
        hspd_d       = hspd_q;
        vspd_d       = vspd_q;
        hold_cnt_d   = hold_cnt_q;
        h_bounce_d   = 1'b0;
        v_bounce_d   = 1'b0;
        goal_left_d  = 1'b0;
        goal_right_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (serve_valid) begin
                    hspd_d  = serve_hspeed;
                    vspd_d  = serve_vspeed;
                    hdir_d  = serve_hdir;
                    vdir_d  = serve_vdir;
                    state_d = MOVING;
                end
            end
            MOVING: begin
                if (tick) begin
                    vpos_d     = v_step.pos;
                    vdir_d     = v_step.dir;
                    v_bounce_d = v_step.pulse;
                    if (H_MODE == 0) begin
                        hpos_d     = h_step.pos;
                        hdir_d     = h_step.dir;
                        h_bounce_d = h_step.pulse;
                    end else if (H_MODE == 1) begin
                        if (h_n > H_LIM)      hpos_d = POS_W'(h_n - H_LIM - ext_t'(1));
                        else if (h_n[EW-1])   hpos_d = POS_W'(h_n + H_LIM + ext_t'(1));
                        else                  hpos_d = POS_W'(h_n);
                    end else begin
                        if (h_n[EW-1]) begin
                            hpos_d      = '0;
                            goal_left_d = 1'b1;
                            hold_cnt_d  = '0;
                            state_d     = HOLD;
                        end else if (h_n > H_LIM) begin
                            hpos_d       = H_MAX_P;
                            goal_right_d = 1'b1;
                            hold_cnt_d   = '0;
                            state_d      = HOLD;
                        end else begin
                            hpos_d = POS_W'(h_n);
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (hold_cnt_q == CNT_LAST) begin
                        hpos_d  = START_H_P;
                        vpos_d  = START_V_P;
                        state_d = IDLE;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            hpos_q     <= START_H_P;
            vpos_q     <= START_V_P;
            hdir_q     <= 1'b0;
            vdir_q     <= 1'b0;
            hspd_q     <= '0;
            vspd_q     <= '0;
            hold_cnt_q <= '0;
            h_bounce   <= 1'b0;
            v_bounce   <= 1'b0;
            goal_left  <= 1'b0;
            goal_right <= 1'b0;
        end else begin
            state_q    <= state_d;
            hpos_q     <= hpos_d;
            vpos_q     <= vpos_d;
            hdir_q     <= hdir_d;
            vdir_q     <= vdir_d;
            hspd_q     <= hspd_d;
            vspd_q     <= vspd_d;
            hold_cnt_q <= hold_cnt_d;
            h_bounce   <= h_bounce_d;
            v_bounce   <= v_bounce_d;
            goal_left  <= goal_left_d;
            goal_right <= goal_right_d;
        end
    end

    assign ball_hpos   = hpos_q;
    assign ball_vpos   = vpos_q;
    assign ball_hdir   = hdir_q;
    assign ball_vdir   = vdir_q;
    assign serve_ready = (state_q == IDLE);
    assign active      = (state_q == MOVING);

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Scoreboard bench for ball_motion_ctrl: one instance per horizontal edge mode on shared stimulus.
module tb_ball_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       serve_valid = 1'b0;
    logic [3:0] serve_hspeed = '0;
    logic [3:0] serve_vspeed = '0;
    logic       serve_hdir = 1'b0;
    logic       serve_vdir = 1'b0;

    logic [8:0] hpos [3];
    logic [8:0] vpos [3];
    logic       hdir [3];
    logic       vdir [3];
    logic       ready [3];
    logic       act [3];
    logic       hb [3];
    logic       vb [3];
    logic       gl [3];
    logic       gr [3];

    int errors = 0;
    int checks = 0;

    typedef struct {
        int mode;
        int h;
        int v;
        int hb;
        int vb;
        int gl;
        int gr;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    ball_motion_ctrl #(.H_MODE(0)) dut_bounce (
        .clk(clk), .reset(reset), .tick(tick), .serve_valid(serve_valid), .serve_ready(ready[0]),
        .serve_hspeed(serve_hspeed), .serve_vspeed(serve_vspeed), .serve_hdir(serve_hdir),
        .serve_vdir(serve_vdir), .ball_hpos(hpos[0]), .ball_vpos(vpos[0]), .ball_hdir(hdir[0]),
        .ball_vdir(vdir[0]), .active(act[0]), .h_bounce(hb[0]), .v_bounce(vb[0]),
        .goal_left(gl[0]), .goal_right(gr[0]));

    ball_motion_ctrl #(.H_MODE(1)) dut_wrap (
        .clk(clk), .reset(reset), .tick(tick), .serve_valid(serve_valid), .serve_ready(ready[1]),
        .serve_hspeed(serve_hspeed), .serve_vspeed(serve_vspeed), .serve_hdir(serve_hdir),
        .serve_vdir(serve_vdir), .ball_hpos(hpos[1]), .ball_vpos(vpos[1]), .ball_hdir(hdir[1]),
        .ball_vdir(vdir[1]), .active(act[1]), .h_bounce(hb[1]), .v_bounce(vb[1]),
        .goal_left(gl[1]), .goal_right(gr[1]));

    ball_motion_ctrl #(.H_MODE(2)) dut_goal (
        .clk(clk), .reset(reset), .tick(tick), .serve_valid(serve_valid), .serve_ready(ready[2]),
        .serve_hspeed(serve_hspeed), .serve_vspeed(serve_vspeed), .serve_hdir(serve_hdir),
        .serve_vdir(serve_vdir), .ball_hpos(hpos[2]), .ball_vpos(vpos[2]), .ball_hdir(hdir[2]),
        .ball_vdir(vdir[2]), .active(act[2]), .h_bounce(hb[2]), .v_bounce(vb[2]),
        .goal_left(gl[2]), .goal_right(gr[2]));

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        tick = 1'b0;
        serve_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic serve(input int hs, input int vs, input bit hd, input bit vd, input bit with_tick);
        @(negedge clk);
        serve_valid  = 1'b1;
        serve_hspeed = 4'(hs);
        serve_vspeed = 4'(vs);
        serve_hdir   = hd;
        serve_vdir   = vd;
        tick         = with_tick;
        @(negedge clk);
        serve_valid = 1'b0;
        tick        = 1'b0;
    endtask

    task automatic expect_step(input int mode, input int h, input int v,
                               input int b_h, input int b_v, input int g_l, input int g_r);
        exp_t e;
        e.mode = mode; e.h = h; e.v = v; e.hb = b_h; e.vb = b_v; e.gl = g_l; e.gr = g_r;
        sb.push_back(e);
    endtask

    // Drive one tick, then compare the oldest scoreboard entry once the result is registered.
    task automatic tick_and_compare(input string tag);
        exp_t e;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, "_hpos"}, int'(hpos[e.mode]), e.h);
            check({tag, "_vpos"}, int'(vpos[e.mode]), e.v);
            check({tag, "_hb"}, int'(hb[e.mode]), e.hb);
            check({tag, "_vb"}, int'(vb[e.mode]), e.vb);
            check({tag, "_gl"}, int'(gl[e.mode]), e.gl);
            check({tag, "_gr"}, int'(gr[e.mode]), e.gr);
        end
    endtask

    initial begin
        // Reset state
        apply_reset();
        @(negedge clk);
        check("rst_hpos", int'(hpos[0]), 10);
        check("rst_vpos", int'(vpos[0]), 10);
        check("rst_ready", int'(ready[0]), 1);
        check("rst_active", int'(act[0]), 0);
        check("rst_pulses", int'({hb[0], vb[0], gl[0], gr[0]}), 0);

        // Bounce on both axes
        serve(2, 3, 1'b0, 1'b0, 1'b0);
        check("bnc_active", int'(act[0]), 1);
        check("bnc_ready", int'(ready[0]), 0);
        expect_step(0, 12, 13, 0, 0, 0, 0);
        expect_step(0, 14, 16, 0, 0, 0, 0);
        expect_step(0, 16, 19, 0, 0, 0, 0);
        expect_step(0, 18, 18, 0, 1, 0, 0);
        expect_step(0, 20, 15, 1, 0, 0, 0);
        expect_step(0, 18, 12, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick_and_compare($sformatf("bnc%0d", i + 1));
        check("bnc_hdir", int'(hdir[0]), 1);
        check("bnc_vdir", int'(vdir[0]), 1);

        // Upward reflection through zero, horizontal speed 0 holds
        apply_reset();
        serve(0, 4, 1'b0, 1'b1, 1'b0);
        expect_step(0, 10, 6, 0, 0, 0, 0);
        expect_step(0, 10, 2, 0, 0, 0, 0);
        expect_step(0, 10, 2, 0, 1, 0, 0);
        expect_step(0, 10, 6, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick_and_compare($sformatf("up%0d", i + 1));

        // Wrap mode
        apply_reset();
        serve(3, 0, 1'b0, 1'b0, 1'b0);
        expect_step(1, 13, 10, 0, 0, 0, 0);
        expect_step(1, 16, 10, 0, 0, 0, 0);
        expect_step(1, 19, 10, 0, 0, 0, 0);
        expect_step(1, 1, 10, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick_and_compare($sformatf("wrap%0d", i + 1));
        check("wrap_hdir", int'(hdir[1]), 0);

        // Goal mode, left goal then park
        apply_reset();
        serve(4, 0, 1'b1, 1'b0, 1'b0);
        expect_step(2, 6, 10, 0, 0, 0, 0);
        expect_step(2, 2, 10, 0, 0, 0, 0);
        expect_step(2, 0, 10, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) tick_and_compare($sformatf("goal%0d", i + 1));
        @(negedge clk);
        check("goal_pulse_width", int'(gl[2]), 0);
        check("hold_active", int'(act[2]), 0);
        check("hold_ready", int'(ready[2]), 0);
        expect_step(2, 0, 10, 0, 0, 0, 0);
        expect_step(2, 10, 10, 0, 0, 0, 0);
        tick_and_compare("hold1");
        check("hold1_ready", int'(ready[2]), 0);
        tick_and_compare("hold2");
        check("park_ready", int'(ready[2]), 1);

        // Goal mode, right goal with vertical still moving on the goal tick
        apply_reset();
        serve(6, 2, 1'b0, 1'b0, 1'b0);
        expect_step(2, 16, 12, 0, 0, 0, 0);
        expect_step(2, 20, 14, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) tick_and_compare($sformatf("goalr%0d", i + 1));

        // Serve with tick in the same cycle, then serve held during MOVING
        apply_reset();
        serve(1, 1, 1'b0, 1'b0, 1'b1);
        check("srvtick_hpos", int'(hpos[0]), 10);
        check("srvtick_vpos", int'(vpos[0]), 10);
        check("srvtick_active", int'(act[0]), 1);
        @(negedge clk);
        serve_valid  = 1'b1;
        serve_hspeed = 4'd5;
        serve_vspeed = 4'd5;
        serve_hdir   = 1'b1;
        serve_vdir   = 1'b1;
        expect_step(0, 11, 11, 0, 0, 0, 0);
        tick_and_compare("held_serve");
        serve_valid = 1'b0;
        check("held_hdir", int'(hdir[0]), 0);

        // Asynchronous reset between clock edges
        expect_step(0, 12, 12, 0, 0, 0, 0);
        tick_and_compare("pre_rst");
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_hpos", int'(hpos[0]), 10);
        check("async_vpos", int'(vpos[0]), 10);
        check("async_active", int'(act[0]), 0);
        check("async_ready", int'(ready[0]), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", int'(ready[0]), 1);

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0, expected 1 (bench did not finish)");
        $fatal(1);
    end

endmodule
